// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset and
// chip-enable levels, default PC/NOP words, FSM state encoding and the
// sequential PC increment.
package if_stage_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    typedef logic [InstAddrBus-1:0] inst_addr_t;
    typedef logic [InstBus-1:0]     inst_t;

    localparam inst_addr_t ZeroWord = 32'h0000_0000;
    localparam inst_t      NOP_INST = 32'h0000_0000;
    localparam inst_addr_t RESET_PC = 32'h0000_0000;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b0;  // reset asserted when low

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Sequential fetch step; wraps naturally modulo 2^32.
    function automatic inst_addr_t pc_inc(input inst_addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Next-PC selector for the fetch stage. Purely combinational; priority is
// flush > stall (hold) > live branch > pending redirect > sequential.
// 'advance' marks an edge on which the current instruction moves to decode.
module pc_next_sel
    import if_stage_pkg::*;
(
    input  logic       active,
    input  logic       flush,
    input  logic       stall,
    input  logic       branch,
    input  logic       pend_valid,
    input  inst_addr_t pc,
    input  inst_addr_t new_pc,
    input  inst_addr_t branch_target,
    input  inst_addr_t pend_target,
    output inst_addr_t next_pc,
    output logic       advance
);

    // Pick the address the fetch PC takes on the coming edge.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        next_pc = pc;
        advance = 1'b0;
        if (active) begin
            if (flush) begin
                next_pc = new_pc;
            end else if (!stall) begin
                advance = 1'b1;
                if (branch) begin
                    next_pc = branch_target;
                end else if (pend_valid) begin
                    next_pc = pend_target;
                end else begin
                    next_pc = pc_inc(pc);
                end
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the ROM address/enable, registers the
// fetched word into the decode pipeline register, and remembers a branch
// seen during a stall so it is applied on release.
// Optional feature: define FETCH_ALIGN_CHK_EN to flag misaligned fetch
// addresses on id_excp_o (instruction replaced by NOP_INST).
module if_stage
    import if_stage_pkg::inst_addr_t, if_stage_pkg::inst_t, if_stage_pkg::fetch_state_e,
           if_stage_pkg::IDLE, if_stage_pkg::FETCH, if_stage_pkg::HOLD,
           if_stage_pkg::ZeroWord, if_stage_pkg::ChipEnable, if_stage_pkg::ChipDisable,
           if_stage_pkg::RstEnable;
#(
    parameter inst_addr_t RESET_PC = if_stage_pkg::RESET_PC,
    parameter inst_t      NOP_INST = if_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic        ce_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_excp_o
);

    fetch_state_e state_q, state_d;
    inst_addr_t   pc_q, next_pc, pend_target_q, id_pc_q;
    inst_t        id_inst_q, fetched_inst;
    logic         id_valid_q, pend_valid_q, advance, active, ce;

    assign active = (state_q != IDLE);

    pc_next_sel u_pc_next_sel (
        .active        (active),
        .flush         (flush_i),
        .stall         (stall_i),
        .branch        (branch_flag_i),
        .pend_valid    (pend_valid_q),
        .pc            (pc_q),
        .new_pc        (new_pc_i),
        .branch_target (branch_target_i),
        .pend_target   (pend_target_q),
        .next_pc       (next_pc),
        .advance       (advance)
    );

`ifdef FETCH_ALIGN_CHK_EN
    logic misaligned, id_excp_q;
    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign fetched_inst = misaligned ? NOP_INST : inst_i;

    // Exception flag follows the instruction it describes; cleared by flush.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            id_excp_q <= 1'b0;
        end else if (active && flush_i) begin
            id_excp_q <= 1'b0;
        end else if (advance) begin
            id_excp_q <= misaligned;
        end
    end
    assign id_excp_o = id_excp_q;
`else
    assign fetched_inst = inst_i;
    assign id_excp_o    = 1'b0;
`endif

    // FSM state register with synchronous reset into IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst == RstEnable) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ROM enable: IDLE spends one cycle with the ROM off.
    always_comb begin
        state_d = state_q;
        ce      = ChipEnable;
        case (state_q)
            IDLE: begin
                ce      = ChipDisable;
                state_d = FETCH;
            end
            FETCH, HOLD: begin
                if (flush_i) begin
                    state_d = FETCH;
                end else if (stall_i) begin
                    state_d = HOLD;
                end else begin
                    state_d = FETCH;
                end
            end
            default: begin
                ce      = ChipDisable;
                state_d = IDLE;
            end
        endcase
    end

    // PC, decode pipeline register and pending-redirect bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: only control/datapath registers are reset; there is no storage array here to clear.
        if (rst == RstEnable) begin
            pc_q          <= RESET_PC;
            id_pc_q       <= ZeroWord;
            id_inst_q     <= NOP_INST;
            id_valid_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= ZeroWord;
        end else begin
            pc_q <= next_pc;
            if (active && flush_i) begin
                id_pc_q      <= ZeroWord;
                id_inst_q    <= NOP_INST;
                id_valid_q   <= 1'b0;
                pend_valid_q <= 1'b0;
            end else if (active && stall_i) begin
                // The latest branch seen while stalled wins.
                if (branch_flag_i) begin
                    pend_valid_q  <= 1'b1;
                    pend_target_q <= branch_target_i;
                end
            end else if (advance) begin
                id_pc_q      <= pc_q;
                id_inst_q    <= fetched_inst;
                id_valid_q   <= 1'b1;
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign pc_o       = pc_q;
    assign ce_o       = ce;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a directed vector table, a hand-written
// wrap/alignment sequence, and randomized traffic against a behavioural model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, branch_flag_i;
    logic [31:0] new_pc_i, branch_target_i, inst_i;
    logic [31:0] pc_o, id_pc_o, id_inst_o;
    logic        ce_o, id_valid_o, id_excp_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Combinational ROM contents.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return 32'h1000_0000 + a;
        endcase
    endfunction

    assign inst_i = rom(pc_o);

    if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .inst_i          (inst_i),
        .pc_o            (pc_o),
        .ce_o            (ce_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_excp_o       (id_excp_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_ce,
                             input logic [31:0] e_id_pc, input logic [31:0] e_inst,
                             input logic e_valid, input logic e_excp);
        check({tag, " pc_o"},       pc_o,       e_pc);
        check({tag, " ce_o"},       ce_o,       e_ce);
        check({tag, " id_pc_o"},    id_pc_o,    e_id_pc);
        check({tag, " id_inst_o"},  id_inst_o,  e_inst);
        check({tag, " id_valid_o"}, id_valid_o, e_valid);
        check({tag, " id_excp_o"},  id_excp_o,  e_excp);
    endtask

    // Apply one cycle of inputs, let the edge happen, sample at the falling edge.
    task automatic drive_cycle(input logic r, input logic s, input logic f, input logic b,
                               input logic [31:0] tgt, input logic [31:0] npc);
        rst             = r;
        stall_i         = s;
        flush_i         = f;
        branch_flag_i   = b;
        branch_target_i = tgt;
        new_pc_i        = npc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, stall, flush, branch;
        logic [31:0] target, new_pc;
        logic [31:0] pc, id_pc, id_inst;
        logic        ce, valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic b,
                                input logic [31:0] tgt, input logic [31:0] npc,
                                input logic [31:0] pc, input logic ce, input logic [31:0] id_pc,
                                input logic [31:0] id_inst, input logic valid);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.branch = b;
        v.target = tgt; v.new_pc = npc;
        v.pc = pc; v.ce = ce; v.id_pc = id_pc; v.id_inst = id_inst; v.valid = valid;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic        m_running;
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    logic        m_valid, m_excp;
    logic [31:0] m_pend[$];   // at most one remembered redirect

    task automatic model_edge(input logic r, input logic s, input logic f, input logic b,
                              input logic [31:0] tgt, input logic [31:0] npc);
        if (!r) begin
            m_running = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = NOP;
            m_valid = 1'b0; m_excp = 1'b0; m_pend.delete();
        end else if (!m_running) begin
            m_running = 1'b1;
        end else if (f) begin
            m_pc = npc; m_id_pc = 32'h0; m_id_inst = NOP;
            m_valid = 1'b0; m_excp = 1'b0; m_pend.delete();
        end else if (s) begin
            if (b) begin
                m_pend.delete();
                m_pend.push_back(tgt);
            end
        end else begin
            m_id_pc = m_pc;
            m_valid = 1'b1;
            if (ALIGN_CHK && (m_pc % 4 != 0)) begin
                m_id_inst = NOP; m_excp = 1'b1;
            end else begin
                m_id_inst = rom(m_pc); m_excp = 1'b0;
            end
            if (b)                   m_pc = tgt;
            else if (m_pend.size() > 0) m_pc = m_pend[0];
            else                     m_pc = m_pc + 32'd4;
            m_pend.delete();
        end
    endtask

    initial begin
        logic r, s, f, b;
        logic [31:0] tgt, npc;

        // Reset bring-up, branch, stall with pending branch, flush, precedence, reset discard.
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   NOP,                1'b0));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h0,   1, 32'h0,   NOP,                1'b0));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h4,   1, 32'h0,   32'h11,             1'b1));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h8,   1, 32'h4,   32'h22,             1'b1));
        vecs.push_back(mk(1,0,0,1, 32'h100, 32'h0,  32'h100, 1, 32'h8,   32'h33,             1'b1));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h104, 1, 32'h100, 32'h1000_0100,      1'b1));
        vecs.push_back(mk(1,1,0,0, 32'h0,   32'h0,  32'h104, 1, 32'h100, 32'h1000_0100,      1'b1));
        vecs.push_back(mk(1,1,0,1, 32'h200, 32'h0,  32'h104, 1, 32'h100, 32'h1000_0100,      1'b1));
        vecs.push_back(mk(1,1,0,0, 32'h0,   32'h0,  32'h104, 1, 32'h100, 32'h1000_0100,      1'b1));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h200, 1, 32'h104, 32'h1000_0104,      1'b1));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h204, 1, 32'h200, 32'h1000_0200,      1'b1));
        vecs.push_back(mk(1,1,0,1, 32'h300, 32'h0,  32'h204, 1, 32'h200, 32'h1000_0200,      1'b1));
        vecs.push_back(mk(1,1,1,0, 32'h0,   32'h80, 32'h80,  1, 32'h0,   NOP,                1'b0));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h84,  1, 32'h80,  32'h1000_0080,      1'b1));
        vecs.push_back(mk(1,1,0,1, 32'h400, 32'h0,  32'h84,  1, 32'h80,  32'h1000_0080,      1'b1));
        vecs.push_back(mk(1,0,0,1, 32'h500, 32'h0,  32'h500, 1, 32'h84,  32'h1000_0084,      1'b1));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h504, 1, 32'h500, 32'h1000_0500,      1'b1));
        vecs.push_back(mk(1,1,0,1, 32'h600, 32'h0,  32'h504, 1, 32'h500, 32'h1000_0500,      1'b1));
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   NOP,                1'b0));
        vecs.push_back(mk(1,0,1,0, 32'h0,   32'h80, 32'h0,   1, 32'h0,   NOP,                1'b0));
        vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,  32'h4,   1, 32'h0,   32'h11,             1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].branch,
                        vecs[i].target, vecs[i].new_pc);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ce, vecs[i].id_pc,
                      vecs[i].id_inst, vecs[i].valid, 1'b0);
        end

        // Wrap from the top of the address space, then a misaligned branch target.
        drive_cycle(1,0,1,0, 32'h0, 32'hFFFF_FFFC);
        check_all("wrap_flush", 32'hFFFF_FFFC, 1'b1, 32'h0, NOP, 1'b0, 1'b0);
        drive_cycle(1,0,0,0, 32'h0, 32'h0);
        check_all("wrap_adv", 32'h0, 1'b1, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1'b1, 1'b0);
        drive_cycle(1,0,0,1, 32'h102, 32'h0);
        check_all("mis_branch", 32'h102, 1'b1, 32'h0, 32'h11, 1'b1, 1'b0);
        drive_cycle(1,0,0,0, 32'h0, 32'h0);
        check_all("mis_adv", 32'h106, 1'b1, 32'h102,
                  ALIGN_CHK ? NOP : rom(32'h102), 1'b1, ALIGN_CHK);
        drive_cycle(1,1,1,0, 32'h0, 32'h40);
        check_all("mis_flush", 32'h40, 1'b1, 32'h0, NOP, 1'b0, 1'b0);

        // Randomized traffic against the model; first cycle forces reset to align both.
        for (int i = 0; i < 2000; i++) begin
            r   = (i == 0) ? 1'b0 : ($urandom_range(99) >= 2);
            s   = ($urandom_range(99) < 30);
            f   = ($urandom_range(99) < 6);
            b   = ($urandom_range(99) < 20);
            tgt = $urandom() & 32'hFFFF_FFFC;
            npc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(9) == 0) tgt[1:0] = 2'($urandom_range(3));
            if ($urandom_range(19) == 0) npc[1:0] = 2'($urandom_range(3));
            model_edge(r, s, f, b, tgt, npc);
            drive_cycle(r, s, f, b, tgt, npc);
            check_all($sformatf("rnd%0d", i), m_pc, m_running, m_id_pc, m_id_inst, m_valid, m_excp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, 32'h0000_0000, instruction word driven to decode for bubbles.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 stall_i  in  1  hold fetch PC and decode outputs.
REQ-006 flush_i  in  1  kill in-flight fetch and redirect to new_pc_i.
REQ-007 new_pc_i  in  32  flush redirect target.
REQ-008 branch_flag_i  in  1  branch taken, from decode.
REQ-009 branch_target_i  in  32  branch target address.
REQ-010 inst_i  in  32  instruction word from ROM for pc_o, same cycle (combinational ROM).
REQ-011 pc_o  out  32  fetch address to ROM.
REQ-012 ce_o  out  1  ROM chip enable.
REQ-013 id_pc_o  out  32  registered PC to decode.
REQ-014 id_inst_o  out  32  registered instruction to decode.
REQ-015 id_valid_o  out  1  id_* holds a real instruction.
REQ-016 id_excp_o  out  1  fetch-address exception flag (see Configuration).

Function
REQ-017 States SHALL be IDLE, FETCH, HOLD; reset enters IDLE.
REQ-018 IDLE SHALL drive ce_o=0 and move to FETCH unconditionally on the next edge, with pc_o=RESET_PC.
REQ-019 In FETCH/HOLD ce_o SHALL be 1.
REQ-020 Priority per edge SHALL be: rst > flush_i > stall_i > branch_flag_i/pending redirect > sequential.
REQ-021 Sequential advance (FETCH, no stall): id_pc_o<=pc_o, id_inst_o<=inst_i, id_valid_o<=1, pc_o<=pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-022 Branch in FETCH, no stall: current instruction (delay slot) SHALL pass to decode as REQ-021; pc_o<=branch_target_i.
REQ-023 stall_i=1: pc_o, id_pc_o, id_inst_o, id_valid_o hold; state->HOLD; stall_i=0 returns to FETCH.
REQ-024 branch_flag_i during stall SHALL latch pend_valid=1, pend_target=branch_target_i; a later branch during same stall overwrites pend_target.
REQ-025 First non-stalled edge with pend_valid=1: current instruction passes to decode, pc_o<=pend_target, pend_valid<=0; a simultaneous branch_flag_i SHALL take precedence over pend_target.
REQ-026 flush_i=1 (any state except IDLE, regardless of stall_i): pc_o<=new_pc_i, id_inst_o<=NOP_INST, id_pc_o<=0, id_valid_o<=0, id_excp_o<=0, pend_valid<=0, state->FETCH.
REQ-027 flush_i in IDLE SHALL be ignored.
REQ-028 Latency: instruction at address A appears on id_inst_o one edge after pc_o=A with no stall.

Reset
REQ-029 While rst=0 at an edge: pc_o=RESET_PC, ce_o=0, id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0, id_excp_o=0, pend_valid=0, pend_target=0, state=IDLE.
REQ-030 Reset mid-stall or mid-pending-redirect SHALL discard all pending state.

Configuration
REQ-031 Macro FETCH_ALIGN_CHK_EN defined: on an advancing edge with pc_o[1:0]!=0, id_inst_o<=NOP_INST, id_valid_o<=1, id_excp_o<=1; PC update unchanged.
REQ-032 Macro undefined: id_excp_o tied 0, pc_o[1:0] ignored, no alignment logic.

Structure
REQ-033 Shared defines package SHALL hold ZeroWord, InstAddrBus, InstBus, NOP_INST, RESET_PC, state encodings, ChipEnable/ChipDisable, RstEnable (active-low).
REQ-034 One combinational sub-module pc_next_sel SHALL compute next PC from flush/stall/branch/pending/sequential inputs; registers stay in if_stage.

Verification
REQ-035 Reset release, no stall, ROM[0..3]=11,22,33,44: pc_o 0,0,4,8,C; id_inst_o NOP,11,22,33 with id_valid_o 0,1,1,1; ce_o 0 then 1.
REQ-036 branch_flag_i=1, target 0x100 while pc_o=0x8: id_pc_o=0x8 next edge, pc_o=0x100.
REQ-037 stall_i 3 cycles with branch to 0x200 in cycle 2: outputs frozen; release edge pc_o=0x200, stalled instruction delivered once.
REQ-038 flush_i with new_pc_i=0x80 while stalled and pending: id_valid_o=0, id_inst_o=NOP, pc_o=0x80, pending cleared.
REQ-039 pc_o=0xFFFF_FFFC advance -> pc_o=0; with FETCH_ALIGN_CHK_EN, branch to 0x102 -> next id_excp_o=1, id_inst_o=NOP.
